logic_pipe_unit: RTL and testbench

- Parametrised, pipelined successor to the team's single-bit AND gate.
- Applies one of eight bitwise operations, selected per transaction, to two WIDTH-bit operands.
- Returns the result with zero, parity and popcount flags through a two-stage valid/ready pipeline.
- Sits in digitalLogic/ as the reusable logic datapath for the RISC-V ALU and the bit-manipulation experiments.

---
 rtl/logic_pkg.sv | 23 ++
 rtl/logic_pipe_unit_bitwise_op_core.sv | 44 ++++
 rtl/logic_pipe_unit.sv | 119 +++++++++++
 tb/tb_logic_pipe_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/logic_pkg.sv
// Shared definitions for the pipelined bitwise logic unit: op encoding and
// the popcount width helper.
package logic_pkg;

    localparam int OP_W = 3;

    typedef enum logic [OP_W-1:0] {
        OP_AND  = 3'd0,
        OP_OR   = 3'd1,
        OP_XOR  = 3'd2,
        OP_NAND = 3'd3,
        OP_NOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_ANDN = 3'd6,
        OP_NOTA = 3'd7
    } op_e;

    // Bits needed to hold a count in 0..width inclusive.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/logic_pipe_unit_bitwise_op_core.sv
// Combinational core: selected bitwise operation on two operands plus
// zero, parity and popcount flags of the result.
module bitwise_op_core
    import logic_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  op_e              op,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             parity,
    output logic [CNT_W-1:0] popcnt
);

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = '0;
        case (op)
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_NAND: result = ~(a & b);
            OP_NOR:  result = ~(a | b);
            OP_XNOR: result = ~(a ^ b);
            OP_ANDN: result = a & ~b;
            OP_NOTA: result = ~a;
            default: result = '0;
        endcase
    end

    always_comb begin
        popcnt = '0;
        for (int i = 0; i < WIDTH; i++) begin
            popcnt = popcnt + CNT_W'(result[i]);
        end
    end

    assign zero   = (popcnt == '0);
    assign parity = ^result;

endmodule

// File: rtl/logic_pipe_unit.sv
// Two-stage valid/ready pipeline around bitwise_op_core: S1 holds the
// accepted operands, S2 holds the registered result and flags.
module logic_pipe_unit
    import logic_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = cnt_w(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [OP_W-1:0]  in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_zero,
    output logic             out_parity,
    output logic [CNT_W-1:0] out_popcnt
);

    logic             s1_adv, s2_adv;

    logic             s1_valid_d, s1_valid_q;
    logic [WIDTH-1:0] s1_a_d, s1_a_q;
    logic [WIDTH-1:0] s1_b_d, s1_b_q;
    op_e              s1_op_d, s1_op_q;

    logic             s2_valid_d, s2_valid_q;
    logic [WIDTH-1:0] s2_result_d, s2_result_q;
    logic             s2_zero_d, s2_zero_q;
    logic             s2_parity_d, s2_parity_q;
    logic [CNT_W-1:0] s2_popcnt_d, s2_popcnt_q;

    logic [WIDTH-1:0] core_result;
    logic             core_zero, core_parity;
    logic [CNT_W-1:0] core_popcnt;

    bitwise_op_core #(.WIDTH(WIDTH)) u_core (
        .a      (s1_a_q),
        .b      (s1_b_q),
        .op     (s1_op_q),
        .result (core_result),
        .zero   (core_zero),
        .parity (core_parity),
        .popcnt (core_popcnt)
    );

    always_comb begin
        // Ready ripples back from the output so a full pipe still moves every cycle.
        s2_adv = !s2_valid_q || out_ready;
        s1_adv = !s1_valid_q || s2_adv;

        s1_valid_d  = s1_valid_q;
        s1_a_d      = s1_a_q;
        s1_b_d      = s1_b_q;
        s1_op_d     = s1_op_q;
        s2_valid_d  = s2_valid_q;
        s2_result_d = s2_result_q;
        s2_zero_d   = s2_zero_q;
        s2_parity_d = s2_parity_q;
        s2_popcnt_d = s2_popcnt_q;

        if (s1_adv) begin
            s1_valid_d = in_valid;
            if (in_valid) begin
                s1_a_d  = in_a;
                s1_b_d  = in_b;
                s1_op_d = op_e'(in_op);
            end
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_result_d = core_result;
                s2_zero_d   = core_zero;
                s2_parity_d = core_parity;
                s2_popcnt_d = core_popcnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: every pipeline register is reset so outputs read zero during reset.
            s1_valid_q  <= 1'b0;
            s1_a_q      <= '0;
            s1_b_q      <= '0;
            s1_op_q     <= OP_AND;
            s2_valid_q  <= 1'b0;
            s2_result_q <= '0;
            s2_zero_q   <= 1'b0;
            s2_parity_q <= 1'b0;
            s2_popcnt_q <= '0;
        end else begin
            // NOTE: non-blocking so all stages update from the same pre-edge values.
            s1_valid_q  <= s1_valid_d;
            s1_a_q      <= s1_a_d;
            s1_b_q      <= s1_b_d;
            s1_op_q     <= s1_op_d;
            s2_valid_q  <= s2_valid_d;
            s2_result_q <= s2_result_d;
            s2_zero_q   <= s2_zero_d;
            s2_parity_q <= s2_parity_d;
            s2_popcnt_q <= s2_popcnt_d;
        end
    end

    assign in_ready   = s1_adv;
    assign out_valid  = s2_valid_q;
    assign out_result = s2_result_q;
    assign out_zero   = s2_zero_q;
    assign out_parity = s2_parity_q;
    assign out_popcnt = s2_popcnt_q;

endmodule

// File: tb/tb_logic_pipe_unit.sv
// Self-checking bench for logic_pipe_unit: WIDTH=8 and WIDTH=1 instances,
// table-driven vectors plus a scoreboard fed at accept and drained at output.
module tb_logic_pipe_unit;

    typedef struct {
        logic [2:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] result;
        logic       zero;
        logic       parity;
        logic [3:0] popcnt;
    } vec_t;

    typedef struct {
        logic [63:0] result;
        logic        zero;
        logic        parity;
        logic [7:0]  popcnt;
    } exp_t;

    int checks = 0;
    int errors = 0;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic       in_valid8, in_ready8, out_valid8, out_ready8;
    logic [2:0] in_op8;
    logic [7:0] in_a8, in_b8, out_result8;
    logic       out_zero8, out_parity8;
    logic [3:0] out_popcnt8;

    logic       in_valid1, in_ready1, out_valid1, out_ready1;
    logic [2:0] in_op1;
    logic       in_a1, in_b1, out_result1;
    logic       out_zero1, out_parity1;
    logic       out_popcnt1;

    exp_t sb8[$];
    exp_t sb1[$];
    vec_t vecs[11];
    logic bp_rand = 1'b0;
    logic [2:0] r_op;
    logic [7:0] r_a, r_b;
    exp_t e0, eb, ec;

    logic_pipe_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op8),
        .in_a(in_a8), .in_b(in_b8),
        .out_valid(out_valid8), .out_ready(out_ready8), .out_result(out_result8),
        .out_zero(out_zero8), .out_parity(out_parity8), .out_popcnt(out_popcnt8)
    );

    logic_pipe_unit #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid1), .in_ready(in_ready1), .in_op(in_op1),
        .in_a(in_a1), .in_b(in_b1),
        .out_valid(out_valid1), .out_ready(out_ready1), .out_result(out_result1),
        .out_zero(out_zero1), .out_parity(out_parity1), .out_popcnt(out_popcnt1)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] op, input logic [7:0] a,
                                   input logic [7:0] b, input int w);
        logic [7:0] r;
        exp_t e;
        case (op)
            3'd0: r = a & b;
            3'd1: r = a | b;
            3'd2: r = a ^ b;
            3'd3: r = ~(a & b);
            3'd4: r = ~(a | b);
            3'd5: r = ~(a ^ b);
            3'd6: r = a & ~b;
            default: r = ~a;
        endcase
        r = r & (8'hFF >> (8 - w));
        e.result = 64'(r);
        e.zero   = (r == 8'h00);
        e.parity = ^r;
        e.popcnt = 8'($countones(r));
        return e;
    endfunction

    function automatic exp_t to_exp(input vec_t v);
        exp_t e;
        e.result = 64'(v.result);
        e.zero   = v.zero;
        e.parity = v.parity;
        e.popcnt = 8'(v.popcnt);
        return e;
    endfunction

    // Output monitors: each handshake pops the oldest expected result.
    always @(negedge clk) begin : mon8
        exp_t e;
        if (rst_n && out_valid8 && out_ready8) begin
            if (sb8.size() == 0) begin
                check("w8_unexpected_output", 64'(out_result8), 64'hDEAD);
            end else begin
                e = sb8.pop_front();
                check("w8_result", 64'(out_result8), e.result);
                check("w8_zero",   64'(out_zero8),   64'(e.zero));
                check("w8_parity", 64'(out_parity8), 64'(e.parity));
                check("w8_popcnt", 64'(out_popcnt8), 64'(e.popcnt));
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rst_n && out_valid1 && out_ready1) begin
            if (sb1.size() == 0) begin
                check("w1_unexpected_output", 64'(out_result1), 64'hDEAD);
            end else begin
                e = sb1.pop_front();
                check("w1_result", 64'(out_result1), e.result);
                check("w1_zero",   64'(out_zero1),   64'(e.zero));
                check("w1_parity", 64'(out_parity1), 64'(e.parity));
                check("w1_popcnt", 64'(out_popcnt1), 64'(e.popcnt));
            end
        end
    end

    always begin
        @(posedge clk);
        #1;
        if (bp_rand) out_ready8 = 1'($urandom_range(0, 1));
    end

    task automatic send8(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input exp_t e);
        in_valid8 = 1'b1; in_op8 = op; in_a8 = a; in_b8 = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready8) begin
                sb8.push_back(e);
                @(posedge clk);
                #1;
                in_valid8 = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send8_timeout: in_ready stayed 0, required 1");
        in_valid8 = 1'b0;
    endtask

    task automatic send1(input logic [2:0] op, input logic a, input logic b, input exp_t e);
        in_valid1 = 1'b1; in_op1 = op; in_a1 = a; in_b1 = b;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (in_ready1) begin
                sb1.push_back(e);
                @(posedge clk);
                #1;
                in_valid1 = 1'b0;
                return;
            end
        end
        checks++; errors++;
        $display("FAIL send1_timeout: in_ready stayed 0, required 1");
        in_valid1 = 1'b0;
    endtask

    task automatic drain8(input string name);
        out_ready8 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb8.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_sb_empty"}, 64'(sb8.size()), 64'd0);
        check({name, "_idle"}, 64'(out_valid8), 64'd0);
    endtask

    task automatic drain1(input string name);
        out_ready1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (sb1.size() == 0) break;
            @(posedge clk);
        end
        repeat (2) @(posedge clk);
        #1;
        check({name, "_sb_empty"}, 64'(sb1.size()), 64'd0);
        check({name, "_idle"}, 64'(out_valid1), 64'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{3'd0, 8'hF0, 8'hCC, 8'hC0, 1'b0, 1'b0, 4'd2};
        vecs[1]  = '{3'd1, 8'hF0, 8'hCC, 8'hFC, 1'b0, 1'b0, 4'd6};
        vecs[2]  = '{3'd2, 8'hF0, 8'hCC, 8'h3C, 1'b0, 1'b0, 4'd4};
        vecs[3]  = '{3'd3, 8'hF0, 8'hCC, 8'h3F, 1'b0, 1'b0, 4'd6};
        vecs[4]  = '{3'd4, 8'hF0, 8'hCC, 8'h03, 1'b0, 1'b0, 4'd2};
        vecs[5]  = '{3'd5, 8'hF0, 8'hCC, 8'hC3, 1'b0, 1'b0, 4'd4};
        vecs[6]  = '{3'd6, 8'hF0, 8'hCC, 8'h30, 1'b0, 1'b0, 4'd2};
        vecs[7]  = '{3'd7, 8'hF0, 8'hCC, 8'h0F, 1'b0, 1'b0, 4'd4};
        vecs[8]  = '{3'd0, 8'hAA, 8'h55, 8'h00, 1'b1, 1'b0, 4'd0};
        vecs[9]  = '{3'd1, 8'hAA, 8'h55, 8'hFF, 1'b0, 1'b0, 4'd8};
        vecs[10] = '{3'd2, 8'h0F, 8'hFF, 8'hF0, 1'b0, 1'b0, 4'd4};

        in_valid8 = 0; in_op8 = 0; in_a8 = 0; in_b8 = 0; out_ready8 = 1;
        in_valid1 = 0; in_op1 = 0; in_a1 = 0; in_b1 = 0; out_ready1 = 1;
        rst_n = 1'b0;

        #2;
        check("rst_out_valid8", 64'(out_valid8), 64'd0);
        check("rst_out_result8", 64'(out_result8), 64'd0);
        check("rst_out_flags8", {61'd0, out_zero8, out_parity8, |out_popcnt8}, 64'd0);
        check("rst_in_ready8", 64'(in_ready8), 64'd1);
        check("rst_out_valid1", 64'(out_valid1), 64'd0);
        check("rst_in_ready1", 64'(in_ready1), 64'd1);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Truth table and flag vectors, back to back with out_ready high.
        for (int i = 0; i < 10; i++) begin
            send8(vecs[i].op, vecs[i].a, vecs[i].b, to_exp(vecs[i]));
            if (i == 0) check("latency_not_yet_valid", 64'(out_valid8), 64'd0);
            if (i == 1) begin
                check("latency_first_valid", 64'(out_valid8), 64'd1);
                check("latency_first_result", 64'(out_result8), 64'hC0);
            end
        end
        drain8("table");

        // Backpressure: two accepts fill the pipe, then in_ready drops.
        out_ready8 = 1'b0;
        e0 = model(3'd0, 8'h3C, 8'h5A, 8);
        send8(3'd0, 8'h3C, 8'h5A, e0);
        send8(3'd1, 8'h3C, 8'h5A, model(3'd1, 8'h3C, 8'h5A, 8));
        check("bp_in_ready_low", 64'(in_ready8), 64'd0);
        check("bp_out_valid", 64'(out_valid8), 64'd1);
        fork
            begin
                send8(3'd2, 8'h3C, 8'h5A, model(3'd2, 8'h3C, 8'h5A, 8));
                send8(3'd7, 8'h3C, 8'h5A, model(3'd7, 8'h3C, 8'h5A, 8));
            end
            begin
                for (int k = 0; k < 4; k++) begin
                    @(negedge clk);
                    check("bp_result_held", 64'(out_result8), e0.result);
                    check("bp_in_ready_stall", 64'(in_ready8), 64'd0);
                end
                @(posedge clk);
                #1;
                out_ready8 = 1'b1;
            end
        join
        drain8("bp");

        // Simultaneous drain and accept on one edge with both stages full.
        out_ready8 = 1'b0;
        send8(3'd5, 8'h12, 8'h34, model(3'd5, 8'h12, 8'h34, 8));
        eb = model(3'd6, 8'hE7, 8'h81, 8);
        send8(3'd6, 8'hE7, 8'h81, eb);
        ec = model(3'd4, 8'h40, 8'h02, 8);
        in_valid8 = 1'b1; in_op8 = 3'd4; in_a8 = 8'h40; in_b8 = 8'h02;
        @(negedge clk);
        check("sim_stalled_ready", 64'(in_ready8), 64'd0);
        @(posedge clk);
        #1;
        out_ready8 = 1'b1;
        @(negedge clk);
        check("sim_ready_with_drain", 64'(in_ready8), 64'd1);
        sb8.push_back(ec);
        @(posedge clk);
        #1;
        in_valid8 = 1'b0;
        check("sim_s2_advanced", 64'(out_result8), eb.result);
        check("sim_out_valid", 64'(out_valid8), 64'd1);
        @(posedge clk);
        #1;
        check("sim_new_reached_s2", 64'(out_result8), ec.result);
        drain8("sim");

        // Asynchronous reset while the pipe is full and stalled.
        out_ready8 = 1'b0;
        send8(3'd1, 8'h81, 8'h18, model(3'd1, 8'h81, 8'h18, 8));
        send8(3'd3, 8'h81, 8'h18, model(3'd3, 8'h81, 8'h18, 8));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid8), 64'd0);
        check("arst_out_result", 64'(out_result8), 64'd0);
        check("arst_out_popcnt", 64'(out_popcnt8), 64'd0);
        check("arst_out_zero", 64'(out_zero8), 64'd0);
        check("arst_in_ready", 64'(in_ready8), 64'd1);
        sb8.delete();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready8 = 1'b1;
        send8(vecs[10].op, vecs[10].a, vecs[10].b, to_exp(vecs[10]));
        drain8("after_reset");

        // Random stream with random backpressure.
        bp_rand = 1'b1;
        for (int i = 0; i < 40; i++) begin
            r_op = 3'($urandom_range(0, 7));
            r_a  = 8'($urandom_range(0, 255));
            r_b  = 8'($urandom_range(0, 255));
            send8(r_op, r_a, r_b, model(r_op, r_a, r_b, 8));
        end
        bp_rand = 1'b0;
        @(posedge clk);
        #2;
        drain8("random");

        // WIDTH=1 instance.
        send1(3'd3, 1'b1, 1'b1, '{64'd0, 1'b1, 1'b0, 8'd0});
        send1(3'd7, 1'b0, 1'b1, '{64'd1, 1'b0, 1'b1, 8'd1});
        for (int op = 0; op < 8; op++) begin
            for (int ab = 0; ab < 4; ab++) begin
                send1(3'(op), ab[1], ab[0],
                      model(3'(op), {7'd0, ab[1]}, {7'd0, ab[0]}, 1));
            end
        end
        drain1("w1");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
